uart_rx_os: RTL

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchronizer, tick-driven frame FSM with
// optional parity and 1-2 stop bits, and a valid/ready output register with overrun flag.
module uart_rx_os #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUDRATE    = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  rx_busy
);
    localparam int TICK_RAW   = CLK_FREQ_HZ / (BAUDRATE * OVERSAMPLE);
    localparam int TICK_COUNT = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW         = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int SW         = $clog2(OVERSAMPLE);
    localparam int BW         = $clog2(DATA_WIDTH);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SMP_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, rx_s_q;
    logic [1:0]              sync_vld_q;
    logic                    armed_q, armed_d;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]           smp_cnt_q, smp_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_pend_q, par_pend_d;
    logic                    frm_pend_q, frm_pend_d;
    logic                    deliver_q, deliver_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    parity_err_q, parity_err_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;
    logic                    tick, bit_end, mid_start;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_pend_d   = par_pend_q;
        frm_pend_d   = frm_pend_q;
        deliver_d    = 1'b0;
        data_d       = data_q;
        valid_d      = valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        // The line only counts as idle once a real high has passed the synchronizer,
        // so a line held low across reset release cannot fake a start bit.
        armed_d      = armed_q | (sync_vld_q[1] & rx_s_q);

        tick      = (tick_cnt_q == TICK_LAST);
        bit_end   = tick && (smp_cnt_q == SMP_LAST);
        mid_start = tick && (smp_cnt_q == SMP_HALF);

        if (state_q != S_IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) smp_cnt_d = bit_end ? '0 : smp_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (mid_start) state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d[bit_cnt_q] = rx_s_q;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_pend_d = ((^shift_q) ^ rx_s_q) != ODD_PAR;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!rx_s_q) frm_pend_d = 1'b1;
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = S_IDLE;
                        deliver_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) smp_cnt_d = '0;

        // Output register never back-pressures the receiver; an unaccepted word is replaced.
        if (deliver_q) begin
            data_d       = shift_q;
            parity_err_d = par_pend_q;
            frame_err_d  = frm_pend_q;
            valid_d      = 1'b1;
            overrun_d    = valid_q && !ready_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            sync_vld_q   <= '0;
            armed_q      <= 1'b0;
            tick_cnt_q   <= '0;
            smp_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_pend_q   <= 1'b0;
            frm_pend_q   <= 1'b0;
            deliver_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= rx;
            rx_s_q       <= sync1_q;
            sync_vld_q   <= {sync_vld_q[0], 1'b1};
            armed_q      <= armed_d;
            tick_cnt_q   <= tick_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_pend_q   <= par_pend_d;
            frm_pend_q   <= frm_pend_d;
            deliver_q    <= deliver_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule
